// File: rtl/collatz_pkg.sv
// collatz_pkg
// Shared definitions for talking to the tt_um_rtfb_collatz core: byte-wide
// control encodings for uio_in, core geometry, and the sweep sequencer state
// type. Imported by collatz_sweep_driver and collatz_sweep_best.
package collatz_pkg;

    // uio_in control bits: bit7 write strobe, bit6 kick, bit5 path-record select.
    localparam logic [7:0] CTRL_WRITE = 8'h80;
    localparam logic [7:0] CTRL_KICK  = 8'h40;
    localparam logic [7:0] CTRL_PREC  = 8'h20;

    // uio_in bits 4:0 address the core's byte registers.
    localparam int ADDR_BITS = 5;

    // Width of the core's iterator register.
    localparam int CORE_BITS = 144;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_KICK     = 3'd2,
        ST_WAIT_ON  = 3'd3,
        ST_WAIT_OFF = 3'd4,
        ST_READ     = 3'd5,
        ST_EMIT     = 3'd6
    } sweep_state_t;

    // Combine control flags with a byte address into a uio_in value.
    function automatic logic [7:0] ctrl_addr(input logic [7:0]           flags,
                                             input logic [ADDR_BITS-1:0] addr);
        return flags | {{(8 - ADDR_BITS){1'b0}}, addr};
    endfunction

endpackage

// File: rtl/collatz_sweep_best.sv
// collatz_sweep_best
// Tracks the candidate with the longest orbit seen in the current sweep.
// Only instantiated when COLLATZ_SWEEP_BEST_EN is defined.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   clear_i            sweep command accepted: forget the previous best
//   update_i           a result is being handed off this cycle
//   start_i            candidate value of that result
//   orbit_len_i        orbit length of that result
//   best_start_o       candidate with the longest orbit so far
//   best_orbit_len_o   that orbit length
module collatz_sweep_best
    import collatz_pkg::*;
#(
    parameter int START_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  update_i,
    input  logic [START_BITS-1:0] start_i,
    input  logic [15:0]           orbit_len_i,
    output logic [START_BITS-1:0] best_start_o,
    output logic [15:0]           best_orbit_len_o
);

    logic [START_BITS-1:0] best_start_q;
    logic [15:0]           best_orbit_len_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            best_start_q     <= '0;
            best_orbit_len_q <= '0;
        end else if (update_i && (orbit_len_i > best_orbit_len_q)) begin
            // Strict compare: on a tie the earlier candidate stays.
            best_start_q     <= start_i;
            best_orbit_len_q <= orbit_len_i;
        end
    end

    assign best_start_o     = best_start_q;
    assign best_orbit_len_o = best_orbit_len_q;

endmodule

// File: rtl/collatz_sweep_driver.sv
// collatz_sweep_driver
// Host-side sequencer for the tt_um_rtfb_collatz core. Accepts a sweep
// command (start value + count), and for each candidate loads the value into
// the core, kicks COMPUTE, waits for it to finish, reads orbit length and path
// record back, and emits one result on a valid/ready stream.
//
// Optional feature: define COLLATZ_SWEEP_BEST_EN to add best_start /
// best_orbit_len, tracking the longest orbit of the current sweep.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   sweep command handshake (ready only in IDLE)
//   cmd_start, cmd_count  first candidate, number of candidates (0 means 1)
//   core_ui_in            write data to the core
//   core_uio_in           {write, kick, prec_sel, addr[4:0]} to the core
//   core_uo_out           registered read data from the core
//   core_uio_oe           bit7 high while the core computes
//   res_valid/res_ready   result handshake
//   res_start             candidate value
//   res_orbit_len         steps taken by this candidate
//   res_path_rec          path record read from the core
//   res_flags             bit0 skip (candidate < 3), bit1 counter saturated
//   best_start, best_orbit_len   (COLLATZ_SWEEP_BEST_EN only)
//   sweep_done            one-cycle pulse after the last result is accepted
module collatz_sweep_driver
    import collatz_pkg::*;
#(
    parameter int START_BITS = 32,
    parameter int CORE_BYTES = CORE_BITS / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [START_BITS-1:0] cmd_start,
    input  logic [15:0]           cmd_count,
    output logic [7:0]            core_ui_in,
    output logic [7:0]            core_uio_in,
    input  logic [7:0]            core_uo_out,
    input  logic [7:0]            core_uio_oe,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [START_BITS-1:0] res_start,
    output logic [15:0]           res_orbit_len,
    output logic [15:0]           res_path_rec,
    output logic [1:0]            res_flags,
`ifdef COLLATZ_SWEEP_BEST_EN
    output logic [START_BITS-1:0] best_start,
    output logic [15:0]           best_orbit_len,
`endif
    output logic                  sweep_done
);

    localparam int                   START_BYTES = START_BITS / 8;
    localparam logic [ADDR_BITS-1:0] LOAD_LAST   = ADDR_BITS'(CORE_BYTES - 1);
    localparam logic [ADDR_BITS-1:0] READ_LAST   = ADDR_BITS'(4);
    localparam logic [START_BITS-1:0] MIN_CAND   = START_BITS'(3);

    sweep_state_t          state_q,       state_d;
    logic [START_BITS-1:0] cur_q,         cur_d;
    logic [15:0]           remaining_q,   remaining_d;
    logic [ADDR_BITS-1:0]  idx_q,         idx_d;
    logic [15:0]           olen_prev_q,   olen_prev_d;
    logic [7:0]            olen_lo_q,     olen_lo_d;
    logic [7:0]            olen_hi_q,     olen_hi_d;
    logic [7:0]            prec_lo_q,     prec_lo_d;
    logic                  res_valid_q,   res_valid_d;
    logic [START_BITS-1:0] res_start_q,   res_start_d;
    logic [15:0]           res_orbit_q,   res_orbit_d;
    logic [15:0]           res_path_q,    res_path_d;
    logic [1:0]            res_flags_q,   res_flags_d;
    logic                  sweep_done_q,  sweep_done_d;
    logic                  cmd_ready_q,   cmd_ready_d;
    logic [7:0]            uio_q,         uio_d;
    logic [7:0]            ui_q,          ui_d;

    logic        cmd_fire;
    logic        res_fire;
    logic        core_busy;
    logic [15:0] olen_now;
    logic        unused_oe_bits;

    assign cmd_fire       = cmd_valid & cmd_ready_q;
    assign res_fire       = res_valid_q & res_ready;
    assign core_busy      = core_uio_oe[7];
    assign olen_now       = {olen_hi_q, olen_lo_q};
    assign unused_oe_bits = ^core_uio_oe[6:0];

    // Next-state and result logic.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // the case leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        cur_d        = cur_q;
        remaining_d  = remaining_q;
        idx_d        = idx_q;
        olen_prev_d  = olen_prev_q;
        olen_lo_d    = olen_lo_q;
        olen_hi_d    = olen_hi_q;
        prec_lo_d    = prec_lo_q;
        res_valid_d  = res_valid_q;
        res_start_d  = res_start_q;
        res_orbit_d  = res_orbit_q;
        res_path_d   = res_path_q;
        res_flags_d  = res_flags_q;
        sweep_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    cur_d       = cmd_start;
                    remaining_d = (cmd_count == 16'd0) ? 16'd1 : cmd_count;
                    idx_d       = '0;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // The core never terminates on 0 and mis-counts 1 and 2, so
                // those candidates are reported without touching the core.
                if (cur_q < MIN_CAND) begin
                    res_valid_d = 1'b1;
                    res_start_d = cur_q;
                    res_orbit_d = 16'd0;
                    res_path_d  = 16'd0;
                    res_flags_d = 2'b01;
                    state_d     = ST_EMIT;
                end else if (idx_q == LOAD_LAST) begin
                    state_d = ST_KICK;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_KICK: state_d = ST_WAIT_ON;

            ST_WAIT_ON: begin
                if (core_busy) state_d = ST_WAIT_OFF;
            end

            ST_WAIT_OFF: begin
                if (!core_busy) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                // Core read data is registered: the byte addressed in cycle
                // r(k) appears on core_uo_out in cycle r(k+1).
                idx_d = idx_q + 1'b1;
                case (idx_q)
                    5'd1: olen_lo_d = core_uo_out;
                    5'd2: olen_hi_d = core_uo_out;
                    5'd3: prec_lo_d = core_uo_out;
                    default: ;
                endcase
                if (idx_q == READ_LAST) begin
                    // The core's orbit counter is cumulative across runs, so
                    // the per-candidate length is the modular difference.
                    res_valid_d = 1'b1;
                    res_start_d = cur_q;
                    res_orbit_d = olen_now - olen_prev_q;
                    res_path_d  = {core_uo_out, prec_lo_q};
                    res_flags_d = {olen_now == 16'hffff, 1'b0};
                    olen_prev_d = olen_now;
                    state_d     = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (res_fire) begin
                    res_valid_d = 1'b0;
                    cur_d       = cur_q + START_BITS'(1);
                    remaining_d = remaining_q - 16'd1;
                    idx_d       = '0;
                    if (remaining_q == 16'd1) begin
                        sweep_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Core-facing outputs are derived from the upcoming state so that the
    // registered value lines up with the cycle spent in that state.
    always_comb begin
        uio_d       = 8'h00;
        ui_d        = 8'h00;
        cmd_ready_d = (state_d == ST_IDLE);

        case (state_d)
            ST_LOAD: begin
                if (cur_d >= MIN_CAND) begin
                    uio_d = ctrl_addr(CTRL_WRITE, idx_d);
                    for (int b = 0; b < START_BYTES; b++) begin
                        if (idx_d == ADDR_BITS'(b)) ui_d = cur_d[8*b +: 8];
                    end
                end
            end
            ST_KICK: uio_d = CTRL_KICK;
            ST_READ: begin
                case (idx_d)
                    5'd0:    uio_d = ctrl_addr(8'h00, 5'd0);
                    5'd1:    uio_d = ctrl_addr(8'h00, 5'd1);
                    5'd2:    uio_d = ctrl_addr(CTRL_PREC, 5'd0);
                    5'd3:    uio_d = ctrl_addr(CTRL_PREC, 5'd1);
                    default: uio_d = 8'h00;
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            remaining_q  <= '0;
            idx_q        <= '0;
            olen_prev_q  <= '0;
            olen_lo_q    <= '0;
            olen_hi_q    <= '0;
            prec_lo_q    <= '0;
            res_valid_q  <= 1'b0;
            res_start_q  <= '0;
            res_orbit_q  <= '0;
            res_path_q   <= '0;
            res_flags_q  <= '0;
            sweep_done_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            uio_q        <= '0;
            ui_q         <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            remaining_q  <= remaining_d;
            idx_q        <= idx_d;
            olen_prev_q  <= olen_prev_d;
            olen_lo_q    <= olen_lo_d;
            olen_hi_q    <= olen_hi_d;
            prec_lo_q    <= prec_lo_d;
            res_valid_q  <= res_valid_d;
            res_start_q  <= res_start_d;
            res_orbit_q  <= res_orbit_d;
            res_path_q   <= res_path_d;
            res_flags_q  <= res_flags_d;
            sweep_done_q <= sweep_done_d;
            cmd_ready_q  <= cmd_ready_d;
            uio_q        <= uio_d;
            ui_q         <= ui_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign core_uio_in   = uio_q;
    assign core_ui_in    = ui_q;
    assign res_valid     = res_valid_q;
    assign res_start     = res_start_q;
    assign res_orbit_len = res_orbit_q;
    assign res_path_rec  = res_path_q;
    assign res_flags     = res_flags_q;
    assign sweep_done    = sweep_done_q;

`ifdef COLLATZ_SWEEP_BEST_EN
    collatz_sweep_best #(
        .START_BITS (START_BITS)
    ) u_best (
        .clk              (clk),
        .reset            (reset),
        .clear_i          (cmd_fire),
        .update_i         (res_fire),
        .start_i          (res_start_q),
        .orbit_len_i      (res_orbit_q),
        .best_start_o     (best_start),
        .best_orbit_len_o (best_orbit_len)
    );
`endif

endmodule

// File: tb/tb_collatz_sweep_driver.sv
`timescale 1ns/1ps
module tb_collatz_sweep_driver;

    localparam int SB = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SB-1:0] cmd_start;
    logic [15:0]   cmd_count;
    logic [7:0]    core_ui_in;
    logic [7:0]    core_uio_in;
    logic [7:0]    core_uo_out;
    logic [7:0]    core_uio_oe;
    logic          res_valid;
    logic          res_ready;
    logic [SB-1:0] res_start;
    logic [15:0]   res_orbit_len;
    logic [15:0]   res_path_rec;
    logic [1:0]    res_flags;
    logic          sweep_done;
`ifdef COLLATZ_SWEEP_BEST_EN
    logic [SB-1:0] best_start;
    logic [15:0]   best_orbit_len;
`endif

    always #5 clk = ~clk;

    collatz_sweep_driver #(.START_BITS(SB), .CORE_BYTES(18)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_start     (cmd_start),
        .cmd_count     (cmd_count),
        .core_ui_in    (core_ui_in),
        .core_uio_in   (core_uio_in),
        .core_uo_out   (core_uo_out),
        .core_uio_oe   (core_uio_oe),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_start     (res_start),
        .res_orbit_len (res_orbit_len),
        .res_path_rec  (res_path_rec),
        .res_flags     (res_flags),
`ifdef COLLATZ_SWEEP_BEST_EN
        .best_start    (best_start),
        .best_orbit_len(best_orbit_len),
`endif
        .sweep_done    (sweep_done)
    );

    // ------------------------------------------------------------------
    // Behavioural core model: byte-writable 144-bit iterator, one Collatz
    // step per cycle while busy, cumulative wrapping 16-bit step counter,
    // registered read data. The path record stand-in is the low 16 bits of
    // the peak iterate so both read bytes carry distinguishable data.
    // ------------------------------------------------------------------
    logic [143:0] m_iter, m_peak, m_next;
    logic [15:0]  m_olen;
    logic         m_busy;
    logic [7:0]   m_rdata;
    int           m_kicks  = 0;
    int           m_writes = 0;
    logic         m_preset_req;
    logic [15:0]  m_preset_val;

    assign m_next      = m_iter[0] ? (m_iter * 144'd3 + 144'd1) : (m_iter >> 1);
    assign core_uo_out = m_rdata;
    assign core_uio_oe = {m_busy, 7'b0};

    always @(posedge clk) begin
        if (reset) begin
            m_iter  <= '0;
            m_peak  <= '0;
            m_olen  <= '0;
            m_busy  <= 1'b0;
            m_rdata <= '0;
        end else begin
            if (m_busy) begin
                if (m_iter == 144'd1) m_busy <= 1'b0;
                else begin
                    m_iter <= m_next;
                    m_olen <= m_olen + 16'd1;
                    if (m_next > m_peak) m_peak <= m_next;
                end
            end else if (core_uio_in[7]) begin
                if (int'(core_uio_in[4:0]) < 18)
                    m_iter[8*int'(core_uio_in[4:0]) +: 8] <= core_ui_in;
                m_writes <= m_writes + 1;
            end else if (core_uio_in == 8'h40) begin
                m_busy  <= 1'b1;
                m_peak  <= m_iter;
                m_kicks <= m_kicks + 1;
            end
            if (m_preset_req) m_olen <= m_preset_val;
            case ({core_uio_in[5], core_uio_in[4:0]})
                6'b0_00000: m_rdata <= m_olen[7:0];
                6'b0_00001: m_rdata <= m_olen[15:8];
                6'b1_00000: m_rdata <= m_peak[7:0];
                6'b1_00001: m_rdata <= m_peak[15:8];
                default:    m_rdata <= 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Checking and reference model
    // ------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] r_cnt  = 16'd0;   // core's cumulative counter, per the rules
    logic [15:0] r_prev = 16'd0;   // counter value at the previous read
    logic [15:0] last_orbit;
    logic [1:0]  last_flags;
    logic [SB-1:0] b_s;
    logic [15:0]   b_o;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Collatz orbit of n down to 1: number of steps and the peak value.
    task automatic ref_orbit(input logic [143:0] n0, output int steps, output logic [143:0] peak);
        logic [143:0] n;
        n = n0; steps = 0; peak = n0;
        while (n != 144'd1 && steps < 100000) begin
            if (n[0]) n = n * 144'd3 + 144'd1;
            else      n = n >> 1;
            if (n > peak) peak = n;
            steps++;
        end
    endtask

    task automatic send_cmd(input logic [SB-1:0] start, input logic [15:0] count, output bit ok);
        cmd_start = start;
        cmd_count = count;
        cmd_valid = 1'b1;
        for (int t = 0; t < 3000 && cmd_ready !== 1'b1; t++) @(negedge clk);
        ok = (cmd_ready === 1'b1);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (ok) check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    endtask

    task automatic wait_valid(output bit ok);
        for (int t = 0; t < 3000 && res_valid !== 1'b1; t++) @(negedge clk);
        ok = (res_valid === 1'b1);
        if (!ok) check("res_valid_timeout", 64'(res_valid), 64'd1);
    endtask

    task automatic run_sweep(input logic [SB-1:0] start, input logic [15:0] count, input int stall_idx);
        int           n, st, k0, w0, ws, expk;
        logic [SB-1:0] c;
        logic [143:0] pk;
        logic [15:0]  eo, ep;
        logic [1:0]   ef;
        bit           ok;
        n = (count == 16'd0) ? 1 : int'(count);
        c = start; expk = 0; k0 = m_kicks; w0 = m_writes;
        b_s = '0; b_o = '0;
        send_cmd(start, count, ok);
        if (!ok) return;
        for (int i = 0; i < n; i++) begin
            if (c < 32'd3) begin
                eo = 16'd0; ep = 16'd0; ef = 2'b01;
            end else begin
                ref_orbit(144'(c), st, pk);
                r_cnt  = r_cnt + 16'(st);
                eo     = r_cnt - r_prev;
                ef     = {r_cnt == 16'hffff, 1'b0};
                r_prev = r_cnt;
                ep     = pk[15:0];
                expk++;
            end
            wait_valid(ok);
            if (!ok) return;
            check("res_start", 64'(res_start), 64'(c));
            check("res_orbit_len", 64'(res_orbit_len), 64'(eo));
            check("res_path_rec", 64'(res_path_rec), 64'(ep));
            check("res_flags", 64'(res_flags), 64'(ef));
            last_orbit = res_orbit_len;
            last_flags = res_flags;
            if (i == stall_idx) begin
                ws = m_writes;
                cmd_start = 32'd99; cmd_count = 16'd7; cmd_valid = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    check("stall_valid", 64'(res_valid), 64'd1);
                    check("stall_start", 64'(res_start), 64'(c));
                    check("stall_orbit", 64'(res_orbit_len), 64'(eo));
                    check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
                end
                cmd_valid = 1'b0;
                check("stall_no_load", 64'(m_writes - ws), 64'd0);
            end
            if (eo > b_o) begin b_o = eo; b_s = c; end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("res_valid_drop", 64'(res_valid), 64'd0);
            check("sweep_done_timing", 64'(sweep_done), (i == n - 1) ? 64'd1 : 64'd0);
            c = c + 32'd1;
        end
        @(negedge clk);
        check("sweep_done_clear", 64'(sweep_done), 64'd0);
        check("cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("kick_count", 64'(m_kicks - k0), 64'(expk));
        check("write_count", 64'(m_writes - w0), 64'(expk * 18));
`ifdef COLLATZ_SWEEP_BEST_EN
        check("best_start", 64'(best_start), 64'(b_s));
        check("best_orbit_len", 64'(best_orbit_len), 64'(b_o));
`endif
    endtask

    initial begin
        bit ok;
        int seen;
        reset = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_count = '0;
        res_ready = 1'b0; m_preset_req = 1'b0; m_preset_val = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_sweep_done", 64'(sweep_done), 64'd0);
        check("rst_uio_in", 64'(core_uio_in), 64'd0);
        check("rst_ui_in", 64'(core_ui_in), 64'd0);
        check("rst_res_start", 64'(res_start), 64'd0);
        check("rst_res_orbit", 64'(res_orbit_len), 64'd0);
        check("rst_res_path", 64'(res_path_rec), 64'd0);
        check("rst_res_flags", 64'(res_flags), 64'd0);

        // Single candidate 27.
        run_sweep(32'd27, 16'd1, -1);
        check("orbit_27", 64'(last_orbit), 64'd111);

        // Skipped candidates 0..2, then 3 computed.
        run_sweep(32'd0, 16'd4, -1);

        // Back-pressure on the first result.
        run_sweep(32'd6, 16'd2, 0);

        // Count 0 behaves as 1.
        run_sweep(32'd5, 16'd0, -1);

        // Longest orbit among 25, 26, 27.
        run_sweep(32'd25, 16'd3, -1);
`ifdef COLLATZ_SWEEP_BEST_EN
        check("best_25_start", 64'(best_start), 64'd27);
        check("best_25_orbit", 64'(best_orbit_len), 64'd111);
`endif

        // Candidate wraps from all-ones to 0; all four value bytes loaded.
        run_sweep(32'hffff_ffff, 16'd2, -1);

        // Randomized sweeps.
        for (int k = 0; k < 3; k++)
            run_sweep(32'($urandom_range(0, 120)), 16'($urandom_range(1, 4)),
                      int'($urandom_range(0, 5)));

        // Push the core's cumulative counter so candidate 3 (7 steps) ends
        // exactly at 16'hffff and candidate 4 wraps it.
        m_preset_val = 16'hfff8; m_preset_req = 1'b1;
        @(negedge clk);
        m_preset_req = 1'b0;
        r_cnt = 16'hfff8;
        run_sweep(32'd3, 16'd2, -1);
        check("wrap_second_orbit", 64'(last_orbit), 64'd2);
        check("wrap_second_flags", 64'(last_flags), 64'd0);

        // Reset while the core computes.
        send_cmd(32'd27, 16'd1, ok);
        for (int t = 0; t < 200 && core_uio_oe[7] !== 1'b1; t++) @(negedge clk);
        check("core_busy_seen", 64'(core_uio_oe[7]), 64'd1);
        repeat (3) @(negedge clk);
        check("pre_reset_cmd_ready", 64'(cmd_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midrst_uio_in", 64'(core_uio_in), 64'd0);
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        reset = 1'b0;
        r_cnt = 16'd0; r_prev = 16'd0;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen++;
        end
        check("midrst_no_result", 64'(seen), 64'd0);

        // Clean sweep after the abort.
        run_sweep(32'd27, 16'd1, -1);
        check("post_rst_orbit_27", 64'(last_orbit), 64'd111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
